// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - 7-segment scan bus monitor: frame rebuild, glyph decode, error and stale detection
module seg_scan_capture #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [7:0]  an,
   input  logic [2:0]  n,
   input  logic        err_clr,
   output logic [63:0] frame,
   output logic [31:0] hex,
   output logic [7:0]  hex_valid,
   output logic        frame_valid,
   output logic [1:0]  err,
   output logic        stale
);

   logic [7:0]       seg_q, an_q, mask;
   logic [2:0]       n_q, n_prev;
   logic [63:0]      shadow;
   logic [CNT_W-1:0] cnt;

   logic [3:0]  num;
   logic [7:0]  low, exp_mask, mask_base, mask_next, hv_next;
   logic [2:0]  idx;
   logic        one_hot, multi, in_range, wr, n_chg, stale_rise, done;
   logic [1:0]  err_set;
   logic [63:0] shadow_next, frame_next;
   logic [31:0] hex_next;
   logic [4:0]  dec;

   // {legal, nibble}; dp (bit 7) is ignored by the caller
   function automatic logic [4:0] dec7(input logic [6:0] s);
      case (s)
         7'h40:   dec7 = 5'h10;
         7'h79:   dec7 = 5'h11;
         7'h24:   dec7 = 5'h12;
         7'h30:   dec7 = 5'h13;
         7'h19:   dec7 = 5'h14;
         7'h12:   dec7 = 5'h15;
         7'h02:   dec7 = 5'h16;
         7'h78:   dec7 = 5'h17;
         7'h00:   dec7 = 5'h18;
         7'h10:   dec7 = 5'h19;
         7'h08:   dec7 = 5'h1A;
         7'h03:   dec7 = 5'h1B;
         7'h46:   dec7 = 5'h1C;
         7'h21:   dec7 = 5'h1D;
         7'h06:   dec7 = 5'h1E;
         7'h0E:   dec7 = 5'h1F;
         default: dec7 = 5'h00;
      endcase
   endfunction

   always_comb begin
      num      = (n_q == 3'd0) ? 4'd8 : {1'b0, n_q};
      low      = ~an_q;
      one_hot  = (low != 8'h00) && ((low & (low - 8'h01)) == 8'h00);
      multi    = (low != 8'h00) && !one_hot;
      idx      = 3'd0;
      for (int k = 7; k >= 0; k--)
         if (low[k]) idx = 3'(k);
      in_range = int'(idx) < int'(num);
      wr       = one_hot && in_range;
      err_set  = {one_hot && !in_range, multi};
      n_chg    = (n_q != n_prev);
      // counter reaches the limit on this edge only when no write resets it
      stale_rise = !wr && (cnt == CNT_W'(TIMEOUT_CYC - 1));

      exp_mask = 8'h00;
      for (int k = 0; k < 8; k++)
         exp_mask[k] = (k < int'(num));
      mask_base = (n_chg || stale_rise) ? 8'h00 : mask;
      mask_next = mask_base | (wr ? (8'h01 << idx) : 8'h00);
      done      = wr && ((mask_next & exp_mask) == exp_mask);

      shadow_next = shadow;
      if (wr) shadow_next[8*idx +: 8] = seg_q;

      frame_next = '1;
      hex_next   = '0;
      hv_next    = '0;
      dec        = '0;
      for (int k = 0; k < 8; k++) begin
         if (exp_mask[k]) frame_next[8*k +: 8] = shadow_next[8*k +: 8];
         dec             = dec7(frame_next[8*k +: 7]);
         hex_next[4*k +: 4] = dec[3:0];
         hv_next[k]      = dec[4] && exp_mask[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q       <= 8'hFF;
         an_q        <= 8'hFF;
         n_q         <= 3'd0;
         n_prev      <= 3'd0;
         shadow      <= '1;
         mask        <= 8'h00;
         frame       <= '1;
         hex         <= '0;
         hex_valid   <= '0;
         frame_valid <= 1'b0;
         err         <= 2'b00;
         cnt         <= '0;
      end else begin
         seg_q       <= seg;
         an_q        <= an;
         n_q         <= n;
         n_prev      <= n_q;
         if (wr) shadow <= shadow_next;
         mask        <= done ? 8'h00 : mask_next;
         frame_valid <= done;
         if (done) begin
            frame     <= frame_next;
            hex       <= hex_next;
            hex_valid <= hv_next;
         end
         err <= (err_clr ? 2'b00 : err) | err_set;
         if (wr)
            cnt <= '0;
         else if (cnt != CNT_W'(TIMEOUT_CYC))
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign stale = (cnt == CNT_W'(TIMEOUT_CYC));

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed vector bench for seg_scan_capture
module tb_seg_scan_capture;
   localparam int T = 16;

   logic        clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
   logic [7:0]  seg = 8'hFF, an = 8'hFF;
   logic [2:0]  n = 3'd4;
   logic [63:0] frame;
   logic [31:0] hex;
   logic [7:0]  hex_valid;
   logic        frame_valid, stale;
   logic [1:0]  err;

   seg_scan_capture #(.TIMEOUT_CYC(T), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .seg(seg), .an(an), .n(n), .err_clr(err_clr),
      .frame(frame), .hex(hex), .hex_valid(hex_valid), .frame_valid(frame_valid),
      .err(err), .stale(stale)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, fv_cnt = 0, base = 0;
   always @(negedge clk) if (frame_valid) fv_cnt++;

   typedef struct packed {
      logic [31:0] segs;
      logic [31:0] hx;
      logic [7:0]  hv;
   } vec_t;

   vec_t        vt [5];
   logic [7:0]  g [16];
   logic [63:0] e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] s, input logic [7:0] a);
      seg = s;
      an  = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int c);
      repeat (c) step(8'hFF, 8'hFF);
   endtask

   task automatic digit(input int k);
      step(g[k], ~(8'h01 << k));
   endtask

   initial begin
      g = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      vt[0] = '{32'hB0A4F9C0, 32'h0000_3210, 8'h0F};
      vt[1] = '{32'hF8829299, 32'h0000_7654, 8'h0F};
      vt[2] = '{32'h83889080, 32'h0000_BA98, 8'h0F};
      vt[3] = '{32'h8E86A1C6, 32'h0000_FEDC, 8'h0F};
      vt[4] = '{32'h0079FF40, 32'h0000_8100, 8'h0D};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_frame", frame, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_hex", hex, 0);
      chk("rst_hex_valid", hex_valid, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_stale", stale, 0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) step(vt[i].segs[8*k +: 8], ~(8'h01 << k));
         chk("vec_fv_early", frame_valid, 0);
         idle(1);
         chk("vec_fv", frame_valid, 1);
         chk("vec_frame", frame, {32'hFFFF_FFFF, vt[i].segs});
         chk("vec_hex", hex, vt[i].hx);
         chk("vec_hex_valid", hex_valid, vt[i].hv);
         idle(1);
         chk("vec_fv_drop", frame_valid, 0);
      end

      // seven digits with a repeated last digit
      n = 3'd7;
      idle(2);
      base = fv_cnt;
      for (int k = 0; k < 6; k++) digit(k);
      digit(6);
      digit(6);
      idle(3);
      chk("n7_fv_count", 64'(fv_cnt - base), 1);
      chk("n7_err", err, 0);
      chk("n7_top_slot", frame[63:56], 8'hFF);
      e = '1;
      for (int k = 0; k < 7; k++) e[8*k +: 8] = g[k];
      chk("n7_frame", frame, e);

      // multiple digit selects mid-scan
      n = 3'd5;
      idle(2);
      digit(0);
      digit(1);
      step(8'h00, 8'hFC);
      idle(1);
      chk("multi_err", err, 2'b01);
      for (int k = 2; k < 5; k++) digit(k);
      idle(1);
      chk("multi_fv", frame_valid, 1);
      e = '1;
      for (int k = 0; k < 5; k++) e[8*k +: 8] = g[k];
      chk("multi_frame", frame, e);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("err_clr", err, 0);

      // digit beyond N
      n = 3'd3;
      idle(2);
      base = fv_cnt;
      step(g[4], 8'hEF);
      idle(2);
      chk("range_err", err, 2'b10);
      chk("range_no_fv", 64'(fv_cnt - base), 0);
      for (int k = 0; k < 3; k++) digit(k);
      idle(1);
      chk("n3_fv", frame_valid, 1);
      chk("n3_frame", frame, {40'hFF_FFFF_FFFF, g[2], g[1], g[0]});
      chk("n3_hex", hex, 32'h0000_0210);
      chk("n3_hex_valid", hex_valid, 8'h07);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;

      // timeout
      digit(0);
      digit(1);
      idle(1);
      chk("stale_after_write", stale, 0);
      idle(T - 1);
      chk("stale_early", stale, 0);
      idle(1);
      chk("stale_rise", stale, 1);
      base = fv_cnt;
      digit(2);
      idle(2);
      chk("stale_mask_cleared", 64'(fv_cnt - base), 0);
      chk("stale_cleared_by_write", stale, 0);

      // asynchronous reset mid-scan
      n = 3'd4;
      idle(2);
      digit(0);
      digit(1);
      digit(2);
      #2 rst = 1'b1;
      #1;
      chk("arst_frame", frame, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("arst_hex", hex, 0);
      chk("arst_hex_valid", hex_valid, 0);
      chk("arst_fv", frame_valid, 0);
      chk("arst_err", err, 0);
      #3 rst = 1'b0;
      base = fv_cnt;
      digit(3);
      idle(3);
      chk("arst_no_fv", 64'(fv_cnt - base), 0);
      for (int k = 0; k < 4; k++) digit(k);
      idle(2);
      chk("arst_rescan_fv", 64'(fv_cnt - base), 1);
      chk("arst_rescan_frame", frame, {32'hFFFF_FFFF, g[3], g[2], g[1], g[0]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
